// File: rtl/apple_bus_drive_arbiter.sv
// apple_bus_drive_arbiter
// Picks which card function drives the Apple II data bus on a CPU read
// cycle and sequences the data-bus transceiver inside the Phi0 window:
// direction turns toward the bus first, output enable follows at a fixed
// phase, and direction is held for one extra cycle after enable drops.
// All outputs are registered.

module apple_bus_drive_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DRIVE_START = 4,
    parameter int DRIVE_END   = 22
) (
    input  logic                   clk_logic,
    input  logic                   system_reset,
    input  logic                   phi0_i,
    input  logic                   addr_valid_i,
    input  logic                   rw_n_i,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic [7:0]             data_o,
    output logic                   data_oe_o,
    output logic                   data_dir_o,
    output logic                   conflict_o,
    output logic                   timeout_o
);

    // Parameter sanity, checked at elaboration.
    if (NUM_REQ < 1 || NUM_REQ > 8) begin : g_bad_num_req
        $error("apple_bus_drive_arbiter: NUM_REQ must be in 1..8");
    end
    if (DRIVE_START < 1 || DRIVE_START >= DRIVE_END || DRIVE_END > 62) begin : g_bad_window
        $error("apple_bus_drive_arbiter: need 1 <= DRIVE_START < DRIVE_END <= 62");
    end

    localparam logic [5:0] CNT_MAX       = 6'd63;
    localparam logic [5:0] DRIVE_ON_CNT  = 6'(DRIVE_START);
    localparam logic [5:0] DRIVE_OFF_CNT = 6'(DRIVE_END);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        DRIVE   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t             state;
    logic               phi0_q;
    logic               phi0_rise;
    logic [5:0]         cnt;
    logic [5:0]         cnt_nxt;
    logic [NUM_REQ-1:0] win_onehot;
    logic               multi_req;
    logic [7:0]         win_data;
    logic [7:0]         grant_data;
    logic               grant_held;

    // Lowest set index wins (fixed priority).
    function automatic logic [NUM_REQ-1:0] lowest_set(input logic [NUM_REQ-1:0] v);
        logic [NUM_REQ-1:0] r;
        logic               found;
        r     = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[k] && !found) begin
                r[k]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // True when more than one requester claims the cycle.
    function automatic logic more_than_one(input logic [NUM_REQ-1:0] v);
        int n;
        n = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            n += int'(v[k]);
        end
        return (n > 1);
    endfunction

    // One-hot mux of the per-requester data slices.
    function automatic logic [7:0] pick_slice(input logic [NUM_REQ-1:0]   sel,
                                              input logic [8*NUM_REQ-1:0] bus);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (sel[k]) begin
                r = r | bus[8*k +: 8];
            end
        end
        return r;
    endfunction

    assign phi0_rise  = phi0_i & ~phi0_q;
    assign win_onehot = lowest_set(req_i);
    assign multi_req  = more_than_one(req_i);
    assign win_data   = pick_slice(win_onehot, req_data_i);
    assign grant_data = pick_slice(grant_o, req_data_i);
    assign grant_held = |(grant_o & req_i);

    // Next phase count: restart on a Phi0 rise, otherwise count up and stick at 63.
    always_comb begin
        cnt_nxt = cnt;
        if (phi0_rise) begin
            cnt_nxt = '0;
        end else if (cnt != CNT_MAX) begin
            cnt_nxt = cnt + 6'd1;
        end
    end

    // Phi0 history and phase counter. The FSM decides on the next-cycle
    // values (phi0_i, cnt_nxt) so its registered outputs line up with the
    // phase count they belong to.
    always_ff @(posedge clk_logic) begin
        if (system_reset) begin
            phi0_q <= 1'b0;
            cnt    <= CNT_MAX;
        end else begin
            phi0_q <= phi0_i;
            cnt    <= cnt_nxt;
        end
    end

    // Arbitration and transceiver sequencing with registered outputs.
    always_ff @(posedge clk_logic) begin
        if (system_reset) begin
            state      <= IDLE;
            grant_o    <= '0;
            data_o     <= '0;
            data_oe_o  <= 1'b0;
            data_dir_o <= 1'b0;
            conflict_o <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            conflict_o <= 1'b0;
            timeout_o  <= 1'b0;
            case (state)
                IDLE: begin
                    grant_o    <= '0;
                    data_o     <= '0;
                    data_oe_o  <= 1'b0;
                    data_dir_o <= 1'b0;
                    if (addr_valid_i && rw_n_i && (|req_i)) begin
                        state      <= ARMED;
                        grant_o    <= win_onehot;
                        data_o     <= win_data;
                        data_dir_o <= phi0_i;
                        conflict_o <= multi_req;
                    end
                end
                ARMED: begin
                    if (!grant_held) begin
                        // Requester withdrew before the drive window opened.
                        state      <= IDLE;
                        grant_o    <= '0;
                        data_o     <= '0;
                        data_dir_o <= 1'b0;
                    end else if (cnt_nxt == CNT_MAX) begin
                        // No Phi0 rise arrived in time; give up on this cycle.
                        state      <= IDLE;
                        grant_o    <= '0;
                        data_o     <= '0;
                        data_dir_o <= 1'b0;
                        timeout_o  <= 1'b1;
                    end else begin
                        data_o     <= grant_data;
                        data_dir_o <= phi0_i;
                        if (phi0_i && (cnt_nxt == DRIVE_ON_CNT)) begin
                            state     <= DRIVE;
                            data_oe_o <= 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    data_o     <= grant_data;
                    data_dir_o <= 1'b1;
                    if (!phi0_i || (cnt_nxt == DRIVE_OFF_CNT)) begin
                        state     <= RELEASE;
                        data_oe_o <= 1'b0;
                    end
                end
                RELEASE: begin
                    // Enable is already off; drop direction one cycle later.
                    state      <= IDLE;
                    grant_o    <= '0;
                    data_o     <= '0;
                    data_oe_o  <= 1'b0;
                    data_dir_o <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    grant_o    <= '0;
                    data_o     <= '0;
                    data_oe_o  <= 1'b0;
                    data_dir_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
